micro_sequencer: RTL and testbench
==================================

# micro_sequencer

Next-address controller for the microprogrammed machine's microprogram counter. Each cycle it decodes the sequencing field of the current microinstruction and drives the counter's load control and parallel-load value: continue, jump, conditional jump, subroutine call/return, wait-on-condition or halt. A start/busy/done handshake lets the top-level control unit launch a microroutine at a given address and observe its completion.

## Interface

- ANCHO, 8: microaddress width; matches the counter width.
- NCOND, 4: number of condition flags.
- STACK_DEPTH, 4: return-stack entries; must be at least 1.

- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  launch request; sampled only in IDLE.
- start_addr  in  ANCHO  entry address of the microroutine.
- upc  in  ANCHO  current counter value, the counter's `cuenta`.
- op  in  3  sequencing field of the microinstruction at upc.
- target  in  ANCHO  branch/call target field.
- cond_sel  in  $clog2(NCOND)  selects the flag to test.
- cond_pol  in  1  the condition is `flags[cond_sel] ^ cond_pol`.
- flags  in  NCOND  datapath status flags.
- ld_c  out  1  to the counter's LD_C: 1 = load, 0 = count.
- cuenta_entrada  out  ANCHO  to the counter's CuentaEntrada.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle completion pulse.
- stack_err  out  1  sticky stack overflow/underflow flag.

## Operation

- States:
  - IDLE: hold the counter with ld_c=1 and cuenta_entrada=upc.
  - RUN: decode op.
  - DONE: hold the counter; done=1; next state is IDLE.
- IDLE with start=1: ld_c=1, cuenta_entrada=start_addr, stack emptied, stack_err cleared, next state RUN.
- start is ignored in RUN and DONE.
- op encoding in RUN (cond = `flags[cond_sel]^cond_pol`):
  - 0 CONT: ld_c=0.
  - 1 JMP: load target.
  - 2 JCOND: load target if cond is true, otherwise ld_c=0.
  - 3 CALL: push upc+1 (mod 2^ANCHO), load target.
  - 4 RET: pop the top entry and load it.
  - 5 WAITC: hold (load upc) while cond is false; ld_c=0 once cond is true.
  - 6 HALT: hold the counter; next state DONE.
  - 7: reserved; executes as CONT.
- Stack boundaries:
  - CALL when the stack is full: no push, jump still taken, stack_err set.
  - RET when the stack is empty: executes as CONT, stack_err set.
  - Depth-1 stack: CALL followed by RET is legal; a second CALL overflows.
- Wrap-around: CONT at address 2^ANCHO-1 wraps to 0 (counter behaviour); the CALL return address wraps the same way.
- Reset values: state IDLE, stack empty, busy=0, done=0, stack_err=0, ld_c=1, cuenta_entrada=upc.

## Timing

- ld_c and cuenta_entrada are combinational from state, op, target, cond and the stack top. They take effect at the next clk edge through the counter, so the latency from microinstruction to new upc is 1 cycle.
- op, target and cond_* must be the fields of the microinstruction at the current upc in the same cycle (combinational microprogram ROM).
- Stack push/pop, state and stack_err update on the same edge as the counter.
- done is high for exactly the cycle after HALT is decoded. busy falls on the following edge.
- Minimum routine length from start to done: start cycle → RUN (HALT) → DONE, so done is high 2 cycles after start.
- rst mid-routine: on the next edge the block returns to IDLE, the stack is emptied and the flags are cleared. The counter keeps its value and is held.

## Configuration

- RETURN_STACK_EN defined: CALL/RET behave as specified above and the stack is built.
- RETURN_STACK_EN undefined:
  - no stack registers are built;
  - CALL executes as JMP;
  - RET executes as CONT;
  - stack_err is tied to 0.

## Structure

- Package micro_seq_pkg holds:
  - the op encoding constants (OP_CONT … OP_HALT);
  - the state typedef (IDLE, RUN, DONE).
- Sub-module micro_return_stack:
  - LIFO with parameters ANCHO and STACK_DEPTH;
  - ports push, pop, clear, din, top, full, empty;
  - instantiated only under RETURN_STACK_EN.
- The counter itself stays outside the block and is connected by the top level.

## Test plan

- Reset, then start with start_addr=0x10 and CONT at 0x10–0x12, HALT at 0x13 → upc sequence 0x10, 0x11, 0x12, 0x13; done pulses once; busy falls; upc holds 0x13.
- JCOND at 0x20 with target=0x40, cond_sel=2, cond_pol=0: flags=4'b0100 → upc=0x40. flags=0 → upc=0x21. With cond_pol=1 the result inverts.
- CALL at 0x05 to 0x30, RET at 0x30 → upc sequence 0x05, 0x30, 0x06. Nested CALLs to depth 4 return in LIFO order. A fifth CALL sets stack_err, still jumps, and does not corrupt the existing entries.
- RET with an empty stack at 0x50 → upc=0x51 and stack_err=1. stack_err stays set until the next accepted start.
- WAITC at 0x08 with the condition false for 3 cycles → upc holds 0x08 for 3 cycles, then moves to 0x09. start pulses during RUN are ignored.
- rst asserted during a nested call → next cycle IDLE, busy=0, ld_c=1; the next RET after a fresh start underflows. With RETURN_STACK_EN undefined, CALL to 0x30 → 0x30 and RET → upc+1.

Source files
------------

// File: rtl/micro_seq_pkg.sv
// Shared definitions for the micro_sequencer next-address controller:
// sequencing-field encoding and controller state type.
package micro_seq_pkg;

  // Sequencing field of the microinstruction (3 bits).
  typedef enum logic [2:0] {
    OP_CONT  = 3'd0,
    OP_JMP   = 3'd1,
    OP_JCOND = 3'd2,
    OP_CALL  = 3'd3,
    OP_RET   = 3'd4,
    OP_WAITC = 3'd5,
    OP_HALT  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/micro_return_stack.sv
// LIFO of return addresses for micro_sequencer CALL/RET.
// Push when full and pop when empty are ignored; the caller flags the error.
module micro_return_stack
  import micro_seq_pkg::*;
#(
  parameter int ANCHO       = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [ANCHO-1:0] din,
  output logic [ANCHO-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ANCHO-1:0] mem_q [STACK_DEPTH];
  logic [CW-1:0]    cnt_q;
  logic [IW-1:0]    top_idx;

  assign full    = (cnt_q == CW'(STACK_DEPTH));
  assign empty   = (cnt_q == '0);
  assign top_idx = IW'(cnt_q - CW'(1));
  assign top     = mem_q[top_idx];

  // Occupancy and storage update; clear has priority over push/pop.
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_q <= '0;
    end else if (push && !full) begin
      mem_q[cnt_q[IW-1:0]] <= din;
      cnt_q                <= cnt_q + CW'(1);
    end else if (pop && !empty) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Next-address controller for the microprogram counter.
// Optional return stack enabled by defining RETURN_STACK_EN; without it
// CALL behaves as JMP, RET as CONT, and stack_err is tied low.
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter int ANCHO       = 8,
  parameter int NCOND       = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ANCHO-1:0]         start_addr,
  input  logic [ANCHO-1:0]         upc,
  input  logic [2:0]               op,
  input  logic [ANCHO-1:0]         target,
  input  logic [$clog2(NCOND)-1:0] cond_sel,
  input  logic                     cond_pol,
  input  logic [NCOND-1:0]         flags,
  output logic                     ld_c,
  output logic [ANCHO-1:0]         cuenta_entrada,
  output logic                     busy,
  output logic                     done,
  output logic                     stack_err
);

  state_e state_q, state_d;
  logic   cond;

  assign cond = flags[cond_sel] ^ cond_pol;
  assign busy = (state_q != IDLE);

`ifdef RETURN_STACK_EN
  logic             stk_push, stk_pop, stk_clear, err_set;
  logic             stk_full, stk_empty;
  logic [ANCHO-1:0] stk_top, ret_addr;
  logic             stack_err_q;

  assign ret_addr  = upc + ANCHO'(1);
  assign stack_err = stack_err_q;

  micro_return_stack #(
    .ANCHO      (ANCHO),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk  (clk),
    .push (stk_push),
    .pop  (stk_pop),
    .clear(stk_clear),
    .din  (ret_addr),
    .top  (stk_top),
    .full (stk_full),
    .empty(stk_empty)
  );

  // Sticky stack error, cleared by reset or an accepted start.
  always_ff @(posedge clk) begin
    if (rst || (state_q == IDLE && start)) stack_err_q <= 1'b0;
    else if (err_set)                      stack_err_q <= 1'b1;
  end
`else
  assign stack_err = 1'b0;
`endif

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and counter control; default is to hold the counter.
  always_comb begin
    state_d        = state_q;
    ld_c           = 1'b1;
    cuenta_entrada = upc;
    done           = 1'b0;
`ifdef RETURN_STACK_EN
    stk_push       = 1'b0;
    stk_pop        = 1'b0;
    stk_clear      = rst;
    err_set        = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          cuenta_entrada = start_addr;
          state_d        = RUN;
`ifdef RETURN_STACK_EN
          stk_clear      = 1'b1;
`endif
        end
      end
      RUN: begin
        case (op_e'(op))
          OP_JMP:   cuenta_entrada = target;
          OP_JCOND: begin
            if (cond) cuenta_entrada = target;
            else      ld_c = 1'b0;
          end
          OP_CALL: begin
            cuenta_entrada = target;
`ifdef RETURN_STACK_EN
            stk_push = !stk_full;
            err_set  = stk_full;
`endif
          end
          OP_RET: begin
`ifdef RETURN_STACK_EN
            if (stk_empty) begin
              ld_c    = 1'b0;
              err_set = 1'b1;
            end else begin
              stk_pop        = 1'b1;
              cuenta_entrada = stk_top;
            end
`else
            ld_c = 1'b0;
`endif
          end
          OP_WAITC: if (cond) ld_c = 1'b0;
          OP_HALT:  state_d = DONE;
          default:  ld_c = 1'b0;
        endcase
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed self-checking bench for micro_sequencer with a behavioural
// counter and a combinational microprogram ROM.
module tb_micro_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, cond_pol, ld_c, busy, done, stack_err;
  logic [7:0] start_addr, upc, target, cuenta_entrada;
  logic [2:0] op;
  logic [1:0] cond_sel;
  logic [3:0] flags;

  logic [2:0] rom_op  [256];
  logic [7:0] rom_tgt [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  micro_sequencer #(.ANCHO(8), .NCOND(4), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .upc(upc),
    .op(op), .target(target), .cond_sel(cond_sel), .cond_pol(cond_pol),
    .flags(flags), .ld_c(ld_c), .cuenta_entrada(cuenta_entrada),
    .busy(busy), .done(done), .stack_err(stack_err)
  );

  // External microprogram counter and ROM.
  initial upc = 8'h00;
  always @(posedge clk) upc <= ld_c ? cuenta_entrada : upc + 8'd1;
  assign op     = rom_op[upc];
  assign target = rom_tgt[upc];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic launch(input logic [7:0] addr);
    start = 1'b1; start_addr = addr;
    step();
    start = 1'b0;
  endtask

  task automatic to_idle();
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      step();
    end
    chk("idle_reached", busy, 0);
  endtask

  task automatic prog(input logic [7:0] a, input logic [2:0] o, input logic [7:0] t);
    rom_op[a] = o; rom_tgt[a] = t;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin rom_op[i] = 3'd0; rom_tgt[i] = 8'h00; end
    rst = 1'b1; start = 1'b0; start_addr = 8'h00;
    cond_sel = 2'd0; cond_pol = 1'b0; flags = 4'h0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", stack_err, 0);
    chk("rst_ldc", ld_c, 1);
    chk("rst_hold", cuenta_entrada, upc);
    rst = 1'b0;

    // Straight-line routine ending in HALT
    prog(8'h13, 3'd6, 8'h00);
    start = 1'b1; start_addr = 8'h10; #1;
    chk("start_ldc", ld_c, 1);
    chk("start_addr", cuenta_entrada, 8'h10);
    step(); start = 1'b0;
    chk("seq0", upc, 8'h10); chk("seq0_busy", busy, 1);
    step(); chk("seq1", upc, 8'h11);
    step(); chk("seq2", upc, 8'h12);
    step(); chk("seq3", upc, 8'h13); chk("seq3_done", done, 0);
    step(); chk("done_pulse", done, 1); chk("done_busy", busy, 1); chk("done_upc", upc, 8'h13);
    step(); chk("after_done", done, 0); chk("busy_fall", busy, 0); chk("hold_upc", upc, 8'h13);
    step(); chk("idle_hold", upc, 8'h13);

    // Conditional jump, both polarities
    prog(8'h20, 3'd2, 8'h40); prog(8'h40, 3'd6, 8'h00); prog(8'h21, 3'd6, 8'h00);
    cond_sel = 2'd2;
    cond_pol = 1'b0; flags = 4'b0100; launch(8'h20); step();
    chk("jcond_taken", upc, 8'h40); to_idle();
    cond_pol = 1'b0; flags = 4'b0000; launch(8'h20); step();
    chk("jcond_fall", upc, 8'h21); to_idle();
    cond_pol = 1'b1; flags = 4'b0000; launch(8'h20); step();
    chk("jcond_inv_taken", upc, 8'h40); to_idle();
    cond_pol = 1'b1; flags = 4'b0100; launch(8'h20); step();
    chk("jcond_inv_fall", upc, 8'h21); to_idle();
    cond_pol = 1'b0; flags = 4'b0000;

    // Reserved op and CONT wrap-around
    prog(8'h2A, 3'd7, 8'h99); prog(8'h2B, 3'd6, 8'h00);
    launch(8'h2A); step(); chk("reserved_cont", upc, 8'h2B); to_idle();
    prog(8'h00, 3'd6, 8'h00);
    launch(8'hFF); step(); chk("cont_wrap", upc, 8'h00); to_idle();

    // Wait on condition; start ignored while running
    prog(8'h08, 3'd5, 8'h00); prog(8'h09, 3'd6, 8'h00);
    cond_sel = 2'd1; flags = 4'b0000;
    launch(8'h08);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; start_addr = 8'h77;
      step();
      chk("waitc_hold", upc, 8'h08);
    end
    start = 1'b0; flags = 4'b0010;
    step(); chk("waitc_release", upc, 8'h09);
    to_idle(); flags = 4'b0000;

    // Simple call / return
    prog(8'h05, 3'd3, 8'h30); prog(8'h30, 3'd4, 8'h00);
    prog(8'h06, 3'd6, 8'h00); prog(8'h31, 3'd6, 8'h00);
    launch(8'h05); chk("call_at", upc, 8'h05);
    step(); chk("call_tgt", upc, 8'h30);
    step();
`ifdef RETURN_STACK_EN
    chk("ret_addr", upc, 8'h06);
`else
    chk("ret_as_cont", upc, 8'h31);
`endif
    chk("call_err", stack_err, 0);
    to_idle();

    // Nested calls: four fit, the fifth overflows
    prog(8'h70, 3'd3, 8'h80); prog(8'h80, 3'd3, 8'h90); prog(8'h90, 3'd3, 8'hA0);
    prog(8'hA0, 3'd3, 8'hB0); prog(8'hB0, 3'd3, 8'hC0); prog(8'hC0, 3'd4, 8'h00);
    prog(8'hA1, 3'd4, 8'h00); prog(8'h91, 3'd4, 8'h00); prog(8'h81, 3'd4, 8'h00);
    prog(8'h71, 3'd6, 8'h00); prog(8'hC1, 3'd6, 8'h00);
    launch(8'h70);
    step(); chk("nest1", upc, 8'h80);
    step(); chk("nest2", upc, 8'h90);
    step(); chk("nest3", upc, 8'hA0);
    step(); chk("nest4", upc, 8'hB0); chk("nest4_err", stack_err, 0);
    step(); chk("nest5", upc, 8'hC0);
`ifdef RETURN_STACK_EN
    chk("overflow_err", stack_err, 1);
    step(); chk("pop1", upc, 8'hA1);
    step(); chk("pop2", upc, 8'h91);
    step(); chk("pop3", upc, 8'h81);
    step(); chk("pop4", upc, 8'h71);
`else
    chk("nostack_err", stack_err, 0);
    step(); chk("nostack_ret", upc, 8'hC1);
`endif
    to_idle();

    // Underflow; flag sticky until next start
    prog(8'h50, 3'd4, 8'h00); prog(8'h51, 3'd6, 8'h00);
    launch(8'h50); chk("err_cleared", stack_err, 0);
    step(); chk("underflow_cont", upc, 8'h51);
`ifdef RETURN_STACK_EN
    chk("underflow_err", stack_err, 1);
    to_idle(); chk("err_sticky", stack_err, 1);
    launch(8'h13); chk("err_clear_on_start", stack_err, 0);
    to_idle();

    // CALL return address wraps
    prog(8'hFF, 3'd3, 8'h35); prog(8'h35, 3'd4, 8'h00);
    launch(8'hFF); step(); chk("wcall_tgt", upc, 8'h35);
    step(); chk("wcall_ret", upc, 8'h00);
    to_idle();
`else
    chk("underflow_noerr", stack_err, 0);
    to_idle();
`endif

    // Reset in the middle of a nested call chain
    launch(8'h70); step(); step();
    chk("pre_rst", upc, 8'h90);
    rst = 1'b1; step();
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ldc", ld_c, 1);
    chk("rst_mid_hold", cuenta_entrada, upc);
    chk("rst_mid_err", stack_err, 0);
    rst = 1'b0;
    launch(8'h50); step();
    chk("post_rst_ret", upc, 8'h51);
`ifdef RETURN_STACK_EN
    chk("post_rst_underflow", stack_err, 1);
`else
    chk("post_rst_noerr", stack_err, 0);
`endif
    to_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
